// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle control FSM for the MIPS-subset CPU.
// Sequences IF -> ID -> EXE -> MEM -> WB over a shared datapath and drives
// write strobes and mux selects from state, opcode, funct and the ALU zero flag.
// Optional build macro MC_MEM_WAIT_EN adds a mem_rdy input. With it, IF and MEM
// stall until the memory reports ready.
module mc_ctrl #(
   parameter int ALUOP_W = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [5:0]         opcode,
   input  logic [5:0]         funct,
   input  logic               zero,
`ifdef MC_MEM_WAIT_EN
   input  logic               mem_rdy,
`endif
   output logic               pc_wr,
   output logic [1:0]         npc_op,
   output logic               ir_wr,
   output logic [1:0]         ext_ctr,
   output logic               alu_src,
   output logic [ALUOP_W-1:0] alu_op,
   output logic               mem_wr,
   output logic               reg_wr,
   output logic               reg_dst,
   output logic               mem_to_reg,
   output logic               illegal,
   output logic [2:0]         state_o
);

   typedef enum logic [2:0] {
      S_IF  = 3'd0,
      S_ID  = 3'd1,
      S_EXE = 3'd2,
      S_MEM = 3'd3,
      S_WB  = 3'd4
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] FN_ADDU  = 6'b100001;
   localparam logic [5:0] FN_SUBU  = 6'b100011;
   localparam logic [5:0] FN_SLT   = 6'b101010;

   localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(3'd0);
   localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(3'd1);
   localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(3'd2);
   localparam logic [ALUOP_W-1:0] ALU_SLT = ALUOP_W'(3'd3);

   state_t             state_r;
   state_t             next_state_s;
   logic               mem_rdy_s;
   logic               is_r_s;
   logic               is_lw_s;
   logic               is_sw_s;
   logic               is_beq_s;
   logic               is_j_s;
   logic               legal_s;
   logic [1:0]         dec_ext_s;
   logic               dec_src_s;
   logic [ALUOP_W-1:0] dec_aluop_s;

`ifdef MC_MEM_WAIT_EN
   assign mem_rdy_s = mem_rdy;
`else
   assign mem_rdy_s = 1'b1;
`endif

   assign state_o = state_r;

   // State register; the low-active reset is sampled on the clock edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= S_IF;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Instruction decode. The EXE-stage selects are derived from the IR alone,
   // so they stay stable through MEM and WB of the same instruction.
   always_comb begin
      is_r_s      = (opcode == OP_RTYPE);
      is_lw_s     = (opcode == OP_LW);
      is_sw_s     = (opcode == OP_SW);
      is_beq_s    = (opcode == OP_BEQ);
      is_j_s      = (opcode == OP_J);
      legal_s     = 1'b0;
      dec_ext_s   = 2'b00;
      dec_src_s   = 1'b0;
      dec_aluop_s = ALU_ADD;
      case (opcode)
         OP_RTYPE: begin
            case (funct)
               FN_ADDU: begin legal_s = 1'b1; dec_aluop_s = ALU_ADD; end
               FN_SUBU: begin legal_s = 1'b1; dec_aluop_s = ALU_SUB; end
               FN_SLT:  begin legal_s = 1'b1; dec_aluop_s = ALU_SLT; end
               default: begin legal_s = 1'b0; dec_aluop_s = ALU_ADD; end
            endcase
         end
         OP_ADDIU: begin legal_s = 1'b1; dec_src_s = 1'b1; dec_aluop_s = ALU_ADD; end
         OP_ORI: begin
            legal_s     = 1'b1;
            dec_ext_s   = 2'b01;
            dec_src_s   = 1'b1;
            dec_aluop_s = ALU_OR;
         end
         OP_LUI: begin
            legal_s     = 1'b1;
            dec_ext_s   = 2'b10;
            dec_src_s   = 1'b1;
            dec_aluop_s = ALU_ADD;
         end
         OP_LW:   begin legal_s = 1'b1; dec_src_s = 1'b1; dec_aluop_s = ALU_ADD; end
         OP_SW:   begin legal_s = 1'b1; dec_src_s = 1'b1; dec_aluop_s = ALU_ADD; end
         OP_BEQ:  begin legal_s = 1'b1; dec_src_s = 1'b0; dec_aluop_s = ALU_SUB; end
         OP_J:    begin legal_s = 1'b1; end
         default: begin legal_s = 1'b0; end
      endcase
   end

   // Next-state and per-cycle strobes/selects; everything is held at 0 in reset.
   always_comb begin
      next_state_s = S_IF;
      pc_wr        = 1'b0;
      npc_op       = 2'b00;
      ir_wr        = 1'b0;
      ext_ctr      = 2'b00;
      alu_src      = 1'b0;
      alu_op       = ALU_ADD;
      mem_wr       = 1'b0;
      reg_wr       = 1'b0;
      reg_dst      = 1'b0;
      mem_to_reg   = 1'b0;
      illegal      = 1'b0;
      if (!rst_n) begin
         next_state_s = S_IF;
      end else begin
         case (state_r)
            S_IF: begin
               // Fetch completes only on a ready cycle; PC and IR load together.
               ir_wr  = mem_rdy_s;
               pc_wr  = mem_rdy_s;
               npc_op = 2'b00;
               if (mem_rdy_s) begin
                  next_state_s = S_ID;
               end else begin
                  next_state_s = S_IF;
               end
            end
            S_ID: begin
               if (is_j_s) begin
                  pc_wr        = 1'b1;
                  npc_op       = 2'b10;
                  next_state_s = S_IF;
               end else if (!legal_s) begin
                  illegal      = 1'b1;
                  next_state_s = S_IF;
               end else begin
                  next_state_s = S_EXE;
               end
            end
            S_EXE: begin
               ext_ctr = dec_ext_s;
               alu_src = dec_src_s;
               alu_op  = dec_aluop_s;
               if (is_beq_s) begin
                  pc_wr        = zero;
                  npc_op       = 2'b01;
                  next_state_s = S_IF;
               end else if (is_lw_s || is_sw_s) begin
                  next_state_s = S_MEM;
               end else begin
                  next_state_s = S_WB;
               end
            end
            S_MEM: begin
               ext_ctr = dec_ext_s;
               alu_src = dec_src_s;
               alu_op  = dec_aluop_s;
               if (is_sw_s) begin
                  // Store is held asserted for the whole access, ready cycle included.
                  mem_wr = 1'b1;
                  if (mem_rdy_s) begin
                     next_state_s = S_IF;
                  end else begin
                     next_state_s = S_MEM;
                  end
               end else if (is_lw_s) begin
                  if (mem_rdy_s) begin
                     next_state_s = S_WB;
                  end else begin
                     next_state_s = S_MEM;
                  end
               end else begin
                  next_state_s = S_IF;
               end
            end
            S_WB: begin
               ext_ctr      = dec_ext_s;
               alu_src      = dec_src_s;
               alu_op       = dec_aluop_s;
               reg_wr       = 1'b1;
               reg_dst      = is_r_s;
               mem_to_reg   = is_lw_s;
               next_state_s = S_IF;
            end
            default: begin
               next_state_s = S_IF;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: table-driven checks of mc_ctrl outputs per cycle, plus
// hand-written cycles-per-instruction and memory-wait sequences.
module tb_mc_ctrl;

   logic       clk;
   logic       rst_n;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       zero;
`ifdef MC_MEM_WAIT_EN
   logic       mem_rdy;
`endif
   logic       pc_wr;
   logic [1:0] npc_op;
   logic       ir_wr;
   logic [1:0] ext_ctr;
   logic       alu_src;
   logic [2:0] alu_op;
   logic       mem_wr;
   logic       reg_wr;
   logic       reg_dst;
   logic       mem_to_reg;
   logic       illegal;
   logic [2:0] state_o;

   int errors;
   int checks;

   typedef struct {
      logic        rst_n;
      logic [5:0]  op;
      logic [5:0]  fn;
      logic        zero;
      logic [17:0] exp;
      string       tag;
   } vec_t;

   vec_t vq[$];

   mc_ctrl #(.ALUOP_W(3)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
`ifdef MC_MEM_WAIT_EN
      .mem_rdy(mem_rdy),
`endif
      .pc_wr(pc_wr), .npc_op(npc_op), .ir_wr(ir_wr), .ext_ctr(ext_ctr),
      .alu_src(alu_src), .alu_op(alu_op), .mem_wr(mem_wr), .reg_wr(reg_wr),
      .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .illegal(illegal),
      .state_o(state_o)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [17:0] ex(input logic [2:0] st, input logic pc,
                                      input logic [1:0] npc, input logic ir,
                                      input logic [1:0] ext, input logic src,
                                      input logic [2:0] aop, input logic mw,
                                      input logic rw, input logic rd,
                                      input logic m2r, input logic ill);
      return {st, pc, npc, ir, ext, src, aop, mw, rw, rd, m2r, ill};
   endfunction

   function automatic logic [17:0] act();
      return {state_o, pc_wr, npc_op, ir_wr, ext_ctr, alu_src, alu_op,
              mem_wr, reg_wr, reg_dst, mem_to_reg, illegal};
   endfunction

   task automatic chk(input string name, input logic [17:0] got, input logic [17:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %b expected %b (st|pc|npc|ir|ext|src|aop|mw|rw|rd|m2r|ill)",
                  name, got, want);
      end
   endtask

   task automatic add(input logic r, input logic [5:0] op, input logic [5:0] fn,
                      input logic z, input logic [17:0] e, input string tag);
      vec_t v;
      v.rst_n = r; v.op = op; v.fn = fn; v.zero = z; v.exp = e; v.tag = tag;
      vq.push_back(v);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Count edges from IF until the FSM is back in IF, bounded at 20.
   task automatic cpi(input logic [5:0] op, input logic [5:0] fn, input int want,
                      input string tag);
      int n;
      do_reset();
      opcode = op; funct = fn; zero = 1'b0;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (state_o != 3'd0 && n < 20);
      checks++;
      if (n != want) begin
         errors++;
         $display("FAIL cpi_%s: got %0d cycles expected %0d", tag, n, want);
      end
   endtask

   initial begin
      logic [17:0] e_if;
      logic [17:0] e_id;
      logic [17:0] e_none;
      errors = 0;
      checks = 0;
      rst_n  = 1'b0;
      opcode = 6'b100011;
      funct  = 6'd0;
      zero   = 1'b0;
`ifdef MC_MEM_WAIT_EN
      mem_rdy = 1'b1;
`endif
      e_if   = ex(3'd0, 1'b1, 2'b00, 1'b1, 2'b00, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      e_id   = ex(3'd1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      e_none = 18'd0;

      // reset held with lw in the IR
      add(1'b0, 6'b100011, 6'd0, 1'b0, e_none, "rst0");
      add(1'b0, 6'b100011, 6'd0, 1'b0, e_none, "rst1");
      add(1'b0, 6'b100011, 6'd0, 1'b0, e_none, "rst2");
      // lw
      add(1'b1, 6'b100011, 6'd0, 1'b0, e_if, "lw_if");
      add(1'b1, 6'b100011, 6'd0, 1'b0, e_id, "lw_id");
      add(1'b1, 6'b100011, 6'd0, 1'b0, ex(3'd2, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "lw_exe");
      add(1'b1, 6'b100011, 6'd0, 1'b0, ex(3'd3, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "lw_mem");
      add(1'b1, 6'b100011, 6'd0, 1'b0, ex(3'd4, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0), "lw_wb");
      // ori
      add(1'b1, 6'b001101, 6'd0, 1'b0, e_if, "ori_if");
      add(1'b1, 6'b001101, 6'd0, 1'b0, e_id, "ori_id");
      add(1'b1, 6'b001101, 6'd0, 1'b0, ex(3'd2, 1'b0, 2'b00, 1'b0, 2'b01, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "ori_exe");
      add(1'b1, 6'b001101, 6'd0, 1'b0, ex(3'd4, 1'b0, 2'b00, 1'b0, 2'b01, 1'b1, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), "ori_wb");
      // lui
      add(1'b1, 6'b001111, 6'd0, 1'b0, e_if, "lui_if");
      add(1'b1, 6'b001111, 6'd0, 1'b0, e_id, "lui_id");
      add(1'b1, 6'b001111, 6'd0, 1'b0, ex(3'd2, 1'b0, 2'b00, 1'b0, 2'b10, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "lui_exe");
      add(1'b1, 6'b001111, 6'd0, 1'b0, ex(3'd4, 1'b0, 2'b00, 1'b0, 2'b10, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), "lui_wb");
      // beq taken, then not taken
      add(1'b1, 6'b000100, 6'd0, 1'b1, e_if, "beq1_if");
      add(1'b1, 6'b000100, 6'd0, 1'b1, e_id, "beq1_id");
      add(1'b1, 6'b000100, 6'd0, 1'b1, ex(3'd2, 1'b1, 2'b01, 1'b0, 2'b00, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "beq1_exe");
      add(1'b1, 6'b000100, 6'd0, 1'b0, e_if, "beq0_if");
      add(1'b1, 6'b000100, 6'd0, 1'b0, e_id, "beq0_id");
      add(1'b1, 6'b000100, 6'd0, 1'b0, ex(3'd2, 1'b0, 2'b01, 1'b0, 2'b00, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "beq0_exe");
      // unsupported opcode, unsupported R funct, then j
      add(1'b1, 6'b111111, 6'd0, 1'b0, e_if, "badop_if");
      add(1'b1, 6'b111111, 6'd0, 1'b0, ex(3'd1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), "badop_id");
      add(1'b1, 6'b000000, 6'b000000, 1'b0, e_if, "badfn_if");
      add(1'b1, 6'b000000, 6'b000000, 1'b0, ex(3'd1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), "badfn_id");
      add(1'b1, 6'b000010, 6'd0, 1'b0, e_if, "j_if");
      add(1'b1, 6'b000010, 6'd0, 1'b0, ex(3'd1, 1'b1, 2'b10, 1'b0, 2'b00, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "j_id");
      // sw
      add(1'b1, 6'b101011, 6'd0, 1'b0, e_if, "sw_if");
      add(1'b1, 6'b101011, 6'd0, 1'b0, e_id, "sw_id");
      add(1'b1, 6'b101011, 6'd0, 1'b0, ex(3'd2, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "sw_exe");
      add(1'b1, 6'b101011, 6'd0, 1'b0, ex(3'd3, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), "sw_mem");
      // R-type subu and slt, addiu
      add(1'b1, 6'b000000, 6'b100011, 1'b0, e_if, "subu_if");
      add(1'b1, 6'b000000, 6'b100011, 1'b0, e_id, "subu_id");
      add(1'b1, 6'b000000, 6'b100011, 1'b0, ex(3'd2, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "subu_exe");
      add(1'b1, 6'b000000, 6'b100011, 1'b0, ex(3'd4, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 3'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0), "subu_wb");
      add(1'b1, 6'b000000, 6'b101010, 1'b0, e_if, "slt_if");
      add(1'b1, 6'b000000, 6'b101010, 1'b0, e_id, "slt_id");
      add(1'b1, 6'b000000, 6'b101010, 1'b0, ex(3'd2, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "slt_exe");
      add(1'b1, 6'b000000, 6'b101010, 1'b0, ex(3'd4, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 3'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0), "slt_wb");
      add(1'b1, 6'b001001, 6'd0, 1'b0, e_if, "addiu_if");
      add(1'b1, 6'b001001, 6'd0, 1'b0, e_id, "addiu_id");
      add(1'b1, 6'b001001, 6'd0, 1'b0, ex(3'd2, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "addiu_exe");
      add(1'b1, 6'b001001, 6'd0, 1'b0, ex(3'd4, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), "addiu_wb");
      // reset mid-instruction: lw aborted in EXE
      add(1'b1, 6'b100011, 6'd0, 1'b0, e_if, "abort_if");
      add(1'b1, 6'b100011, 6'd0, 1'b0, e_id, "abort_id");
      add(1'b0, 6'b100011, 6'd0, 1'b0, ex(3'd2, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "abort_rst");
      add(1'b1, 6'b100011, 6'd0, 1'b0, e_if, "abort_back_if");

      // one edge in reset so the state is defined before the first vector
      @(posedge clk);
      #1;
      foreach (vq[i]) begin
         rst_n  = vq[i].rst_n;
         opcode = vq[i].op;
         funct  = vq[i].fn;
         zero   = vq[i].zero;
         #1;
         chk(vq[i].tag, act(), vq[i].exp);
         @(posedge clk);
         #1;
      end

      cpi(6'b000010, 6'd0, 2, "j");
      cpi(6'b000100, 6'd0, 3, "beq");
      cpi(6'b101011, 6'd0, 4, "sw");
      cpi(6'b000000, 6'b100001, 4, "addu");
      cpi(6'b100011, 6'd0, 5, "lw");

`ifdef MC_MEM_WAIT_EN
      // IF stall, then sw waiting three cycles in MEM
      do_reset();
      opcode  = 6'b101011;
      mem_rdy = 1'b0;
      #1;
      chk("wait_if_hold", act(), e_none);
      mem_rdy = 1'b1;
      #1;
      chk("wait_if_go", act(), e_if);
      repeat (3) @(posedge clk);
      #1;
      mem_rdy = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("wait_sw_mem", act(), ex(3'd3, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
         @(posedge clk);
         #1;
      end
      mem_rdy = 1'b1;
      #1;
      chk("wait_sw_rdy", act(), ex(3'd3, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
      @(posedge clk);
      #1;
      chk("wait_sw_back_if", act(), e_if);
      // reset while stalled in MEM
      repeat (3) @(posedge clk);
      #1;
      mem_rdy = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      chk("wait_rst_in_mem", act(), e_none);
      mem_rdy = 1'b1;
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle control FSM for the MIPS-subset CPU. It sequences the shared datapath: PC, IR, register file, immediate extender, ALU and data memory.
- Decodes opcode/funct held in the external IR and drives per-cycle write strobes and mux selects. This includes the 2-bit extender control (00 sign, 01 zero, 10 upper).
- Replaces the single-cycle combinational controller so one ALU and one memory port are reused across cycles.

Parameters:
- ALUOP_W, 3, width of alu_op output.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- opcode  in  6  IR[31:26]; valid from ID onward.
- funct  in  6  IR[5:0].
- zero  in  1  ALU equality flag, valid in EXE.
- pc_wr  out  1  PC write enable.
- npc_op  out  2  next-PC select: 00 PC+4, 01 branch, 10 jump.
- ir_wr  out  1  IR load enable.
- ext_ctr  out  2  extender mode: 00 signed, 01 zero, 10 upper (imm<<16).
- alu_src  out  1  0 = rt, 1 = extended immediate.
- alu_op  out  ALUOP_W  000 add, 001 sub, 010 or, 011 slt.
- mem_wr  out  1  data memory write enable.
- reg_wr  out  1  register file write enable.
- reg_dst  out  1  0 = rt, 1 = rd.
- mem_to_reg  out  1  0 = ALU result, 1 = memory data.
- illegal  out  1  one-cycle pulse on an unsupported opcode/funct.
- state_o  out  3  current state (IF=0, ID=1, EXE=2, MEM=3, WB=4).

Behaviour:
- Reset (rst_n=0 at a clk edge): state <= IF. While rst_n=0, all strobes (pc_wr, ir_wr, mem_wr, reg_wr, illegal) are forced 0; selects are 0.
- Decoded set:
  - R-type (op 000000): addu 100001, subu 100011, slt 101010.
  - addiu 001001, ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, j 000010.
- Outputs are combinational from state, opcode and funct (and zero). Strobes are 0 in any state not listed below.
- IF: ir_wr=1, pc_wr=1, npc_op=00. Next state ID.
- ID:
  - j: pc_wr=1, npc_op=10, next IF.
  - Unsupported opcode, or R-type with unsupported funct: illegal=1 for this cycle, no writes, next IF.
  - Otherwise next EXE.
- EXE:
  - ext_ctr: 01 for ori; 10 for lui; 00 otherwise.
  - alu_src: 1 for I-type; 0 for R-type and beq.
  - alu_op: add for addu/addiu/lw/sw/lui; sub for subu/beq; or for ori; slt for slt.
  - beq: pc_wr=zero, npc_op=01, next IF.
  - lw/sw: next MEM.
  - All others: next WB.
  - ext_ctr, alu_src and alu_op are held constant through MEM and WB of the same instruction.
- MEM:
  - sw: mem_wr=1, next IF.
  - lw: next WB.
- WB:
  - reg_wr=1.
  - reg_dst=1 for R-type, else 0.
  - mem_to_reg=1 for lw, else 0.
  - Next IF.
- Cycles per instruction: j 2, beq 3, sw 4, R/addiu/ori/lui 4, lw 5.
- rst_n low mid-instruction aborts it; the next edge with rst_n=1 starts from IF.
- Exactly one of pc_wr/mem_wr/reg_wr targets per state. reg_wr and mem_wr are never both high in the same cycle.
- Illegal state encodings (5–7) return to IF on the next edge with all strobes 0.

Optional Feature:
- MC_MEM_WAIT_EN: adds input mem_rdy (1 bit).
- When defined:
  - In MEM, lw/sw remain in MEM until mem_rdy=1.
  - sw asserts mem_wr every waiting cycle. Transition to IF (sw) or WB (lw) occurs on the edge where mem_rdy=1.
  - IF likewise holds, with ir_wr/pc_wr asserted only on the mem_rdy=1 cycle, until mem_rdy=1.
- When undefined: no mem_rdy port; MEM and IF always take one cycle.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with opcode=100011 -> state_o=0, all strobes 0; first cycle after release shows ir_wr=1, pc_wr=1.
- lw (op 100011) -> states 0,1,2,3,4 over 5 cycles; EXE ext_ctr=00, alu_src=1, alu_op=000; WB reg_wr=1, mem_to_reg=1, reg_dst=0.
- ori then lui -> EXE ext_ctr=01 / alu_op=010 for ori, ext_ctr=10 for lui; each reaches WB with reg_wr=1, 4 cycles.
- beq with zero=1, then zero=0 -> EXE pc_wr=1, npc_op=01 in the first case, pc_wr=0 in the second; both return to IF after 3 cycles.
- op 111111, and R-type funct 000000 -> illegal pulses 1 cycle in ID, no pc_wr/reg_wr/mem_wr, back to IF; j (000010) -> ID pc_wr=1, npc_op=10.
- MC_MEM_WAIT_EN, sw with mem_rdy low 3 cycles -> stays in MEM 4 cycles, mem_wr=1 throughout, returns to IF on the cycle after mem_rdy=1; rst_n=0 in MEM -> IF next edge.
